result_display: RTL and testbench
=================================

Name: result_display

Overview:
- Downstream consumer of the Simpson integrator FSM's 16-bit `result`.
- Latches a new result on a load strobe and converts it to BCD with a sequential double-dabble, one bit per cycle.
- Drives a 4-digit, active-low, time-multiplexed 7-segment display (Basys3-style) with leading-zero blanking, an overflow indication and an error pattern.

Parameters:
- WIDTH, 16, width of the binary input value.
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- result  input  WIDTH  unsigned value from the integrator FSM.
- load  input  1  one-cycle strobe; `result` and `err` are sampled when load=1.
- err  input  1  integrator error flag (a > b); sampled with load.
- busy  output  1  conversion in progress.
- ovf  output  1  the displayed value exceeds 9999.
- an  output  4  digit anodes, active-low one-hot; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset values (asynchronous): busy=0, ovf=0, an=4'b1111, seg=7'h7F, dp=1.
  - Stored digits = 0; err latch = 0; scan index = 0; refresh counter = 0.
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE: on load=1, capture result into the shift register and err into err_l. Clear the BCD accumulator (5 digits, 20 bits), set the bit counter to WIDTH, go to SHIFT, set busy=1.
  - SHIFT: each cycle, first add 3 to any BCD nibble that is >=5, then shift {bcd,bin} left by 1 and decrement the counter. After WIDTH cycles, go to DONE.
  - DONE: copy the BCD result into the display registers and set ovf = (ten-thousands digit != 0) and !err_l. Also latch err_l to the display, clear busy, and return to IDLE.
- Latency: load sampled at edge E0, busy high after E0, display registers updated at edge E(WIDTH+1), busy low after that edge. With WIDTH=16 this is 17 cycles.
- The display holds the previous value until DONE; updates are atomic.
- A load while busy restarts the conversion with the new value and err (latest wins). Latency is counted from the new load.
- A load in the DONE cycle is ignored; only a load seen in IDLE or SHIFT is taken.
- Reset mid-conversion aborts; the display returns to the reset content.
- Digit content:
  - Normal: 4 low decimal digits with leading-zero blanking. Blank digit = 7'h7F; digit 0 is never blanked. dp=1.
  - ovf=1: 4 low decimal digits with no blanking, and dp=0 on every digit.
  - err latched: digits 3..0 show 'E','r','r',blank; ovf=0; dp=1.
- Segment codes:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - E=06, r=2F, blank=7F.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index increments modulo 4, and an, seg and dp are registered for the new index one cycle later.
  - The scan runs continuously from reset, independent of busy.
  - The first valid anode (an=4'b1110) appears REFRESH_DIV+1 cycles after reset release.
- Width rule: a 5-digit BCD accumulator suffices for WIDTH<=16. Larger WIDTH requires ceil(WIDTH*0.302)+1 digits, but only 4 digits are shown.

Test Plan:
- REFRESH_DIV=4; reset, then load result=7 -> busy high 17 cycles. Scan then shows an=1110 seg=78, and an=1101/1011/0111 seg=7F; ovf=0, dp=1.
- load result=1234 -> digit3..0 segs 79,24,30,19; no blanking; dp=1 on all digits.
- load result=10678 -> ovf=1; digits 0,6,7,8 (segs 40,02,78,00); dp=0 on all four scan slots.
- load result=5 with err=1 -> digits 3..0 = 06,2F,2F,7F; ovf=0.
- load 1234, then load 42 eight cycles later -> busy stays high until 17 cycles after the second load; 1234 is never displayed; final display is "  42".
- Assert rst_n=0 mid-SHIFT -> busy=0, an=1111, seg=7F immediately. After release and a scan cycle, the display shows "   0".

Source files
------------

// File: rtl/result_display_if.sv
// Result hand-off from the integrator FSM to the display: value, error flag,
// load strobe, plus the converter's busy flag and its FSM state for observation.
interface result_display_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] result;
    logic             load;
    logic             err;
    logic             busy;
    logic [1:0]       state;

    // load is a one-cycle strobe with no ready: it is always accepted in IDLE or
    // SHIFT (a load in SHIFT restarts the conversion) and dropped in DONE;
    // busy is high from the edge that takes a load until the display updates.
    modport master (output result, load, err, input busy, state);
    modport slave  (input result, load, err, output busy, state);
endinterface

// File: rtl/result_display.sv
// Latches a binary result, converts it to BCD by sequential double-dabble and
// drives a 4-digit active-low multiplexed 7-segment display.
module result_display #(
    parameter int WIDTH       = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    result_display_if.slave      bus,
    output logic                 ovf,
    output logic [3:0]           an,
    output logic [6:0]           seg,
    output logic                 dp
);
    localparam int NDIG = (WIDTH <= 16) ? 5 : (WIDTH * 302 + 999) / 1000 + 1;
    localparam int BW   = 4 * NDIG;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int RW   = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  bin;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [CW-1:0]     cnt;
    logic              err_l;
    logic              busy;
    logic [15:0]       disp;
    logic              err_d;

    logic [RW-1:0]     rcnt;
    logic              tick;
    logic [1:0]        idx;
    logic [3:0]        digit;
    logic              blank;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;

    assign bus.busy  = busy;
    assign bus.state = state;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Conversion FSM; the display registers change only in DONE so updates are atomic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            err_l <= 1'b0;
            busy  <= 1'b0;
            disp  <= '0;
            err_d <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, SHIFT: begin
                    if (bus.load) begin
                        bin   <= bus.result;
                        err_l <= bus.err;
                        bcd   <= '0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else if (state == SHIFT) begin
                        {bcd, bin} <= {bcd_adj[BW-2:0], bin, 1'b0};
                        cnt        <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= DONE;
                    end
                end
                DONE: begin
                    disp  <= bcd[15:0];
                    ovf   <= (bcd[BW-1:16] != '0) && !err_l;
                    err_d <= err_l;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign digit = disp[{idx, 2'b00} +: 4];
    assign blank = (idx != 2'd0) && ((disp >> {idx, 2'b00}) == 16'd0);

    always_comb begin
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (err_d) begin
            case (idx)
                2'd3:       seg_nxt = 7'h06;
                2'd2, 2'd1: seg_nxt = 7'h2F;
                default:    seg_nxt = 7'h7F;
            endcase
        end else if (ovf) begin
            seg_nxt = seg_code(digit);
            dp_nxt  = 1'b0;
        end else if (!blank) begin
            seg_nxt = seg_code(digit);
        end
    end

    // tick marks a refresh wrap; the outputs load for the current index on the
    // following edge, which puts the first anode REFRESH_DIV+1 cycles after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            tick <= 1'b0;
            idx  <= 2'd0;
            an   <= 4'b1111;
            seg  <= 7'h7F;
            dp   <= 1'b1;
        end else begin
            tick <= 1'b0;
            if (rcnt == RW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                tick <= 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
            if (tick) begin
                an  <= ~(4'b0001 << idx);
                seg <= seg_nxt;
                dp  <= dp_nxt;
                idx <= idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: random and directed loads checked against an
// arithmetic model of the four displayed digit slots.
module tb_result_display;
    localparam int WIDTH = 16;
    localparam int RD    = 4;
    localparam int LAT   = WIDTH + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ovf;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    result_display_if #(.WIDTH(WIDTH)) bus ();

    result_display #(.WIDTH(WIDTH), .REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .ovf   (ovf),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cur_val;
    bit cur_err;
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] code(input int d);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    // Expected {dp,seg} for slot k (0 = rightmost) when showing val / err.
    function automatic logic [7:0] exp_slot(input int val, input bit e, input int k);
        int p;
        int d;
        case (k)
            0: p = 1;
            1: p = 10;
            2: p = 100;
            default: p = 1000;
        endcase
        d = (val / p) % 10;
        if (e) begin
            case (k)
                3: return {1'b1, 7'h06};
                2, 1: return {1'b1, 7'h2F};
                default: return {1'b1, 7'h7F};
            endcase
        end
        if (val > 9999) return {1'b0, code(d)};
        if (k > 0 && val < p) return {1'b1, 7'h7F};
        return {1'b1, code(d)};
    endfunction

    task automatic scan_sample(input int val, input bit e, inout logic [3:0] seen);
        int k;
        k = -1;
        case (an)
            4'b1110: k = 0;
            4'b1101: k = 1;
            4'b1011: k = 2;
            4'b0111: k = 3;
            default: k = -1;
        endcase
        check("an_onehot", 32'(k >= 0), 32'd1);
        if (k >= 0) begin
            check($sformatf("slot%0d_dp_seg", k), {24'd0, dp, seg}, {24'd0, exp_slot(val, e, k)});
            seen[k] = 1'b1;
        end
    endtask

    task automatic scan_run(input int n, input int val, input bit e);
        logic [3:0] seen;
        seen = 4'h0;
        repeat (n) begin
            scan_sample(val, e, seen);
            @(negedge clk);
        end
        check("scan_cover", {28'd0, seen}, 32'hF);
    endtask

    // Called at a negedge; returns one negedge later with load dropped.
    task automatic do_load(input int v, input bit e);
        bus.result = 16'(v);
        bus.err    = e;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
        bus.result = 16'($urandom);
        bus.err    = 1'($urandom);
    endtask

    // Counts busy cycles while the old value must still be on the display.
    task automatic wait_idle(output int n);
        logic [3:0] seen;
        seen = 4'h0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            scan_sample(cur_val, cur_err, seen);
            @(negedge clk);
        end
    endtask

    task automatic finish_conv();
        logic [16:0] item;
        check("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            item    = exp_q.pop_front();
            cur_err = item[16];
            cur_val = int'(item[15:0]);
        end
        check("ovf", {31'd0, ovf}, 32'(!cur_err && cur_val > 9999));
        check("busy_low", {31'd0, bus.busy}, 32'd0);
        repeat (RD + 2) @(negedge clk);
        scan_run(4 * RD + 4, cur_val, cur_err);
    endtask

    task automatic convert(input int v, input bit e);
        int n;
        do_load(v, e);
        exp_q.push_back({e, 16'(v)});
        wait_idle(n);
        check("latency", n, LAT);
        finish_conv();
    endtask

    task automatic reset_seq();
        int n;
        @(negedge clk);
        rst_n    = 1'b0;
        bus.load = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (an === 4'hF && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("first_anode_delay", n, RD + 1);
        check("first_anode", {28'd0, an}, 32'hE);
        check("first_seg", {25'd0, seg}, 32'h40);
        cur_val = 0;
        cur_err = 1'b0;
        scan_run(4 * RD + 4, 0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int v;
        rst_n      = 1'b0;
        bus.load   = 1'b0;
        bus.result = '0;
        bus.err    = 1'b0;
        reset_seq();

        @(negedge clk);
        convert(7, 1'b0);
        convert(1234, 1'b0);
        convert(10678, 1'b0);
        convert(5, 1'b1);
        convert(9999, 1'b0);
        convert(10000, 1'b0);
        convert(65535, 1'b0);
        convert(100, 1'b0);
        convert(0, 1'b0);

        // Restart: second load eight cycles after the first, latest wins.
        do_load(1234, 1'b0);
        begin
            logic [3:0] seen;
            seen = 4'h0;
            repeat (7) begin
                scan_sample(cur_val, cur_err, seen);
                @(negedge clk);
            end
        end
        do_load(42, 1'b0);
        exp_q.push_back({1'b0, 16'd42});
        wait_idle(n);
        check("restart_latency", n, LAT);
        finish_conv();

        // A load arriving in the DONE cycle is dropped.
        do_load(321, 1'b0);
        exp_q.push_back({1'b0, 16'd321});
        repeat (LAT - 1) @(negedge clk);
        do_load(8765, 1'b1);
        repeat (3) begin
            check("done_load_ignored", {31'd0, bus.busy}, 32'd0);
            @(negedge clk);
        end
        finish_conv();

        repeat (12) begin
            v = int'($urandom_range(0, 65535));
            convert(v, $urandom_range(0, 7) == 0);
        end

        // Reset in the middle of SHIFT aborts and clears the display.
        do_load(4321, 1'b0);
        repeat (5) @(negedge clk);
        reset_seq();
        check("post_reset_ovf", {31'd0, ovf}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
